// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC and the IF/ID pipeline register,
// drives the instruction-memory address and handles redirects, imem wait
// states, decode stalls and misaligned fetch addresses.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_d,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        eret_redirect,
  input  logic [31:0] epc,
  input  logic        exc_redirect,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic        bd_d,
  output logic        adel_d
);

  logic [31:0] pcF_q, pcF_d;
  logic [31:0] ifInstr_q, ifInstr_d;
  logic [31:0] ifPc_q, ifPc_d;
  logic        ifValid_q, ifValid_d;
  logic        ifBd_q, ifBd_d;
  logic        ifAdel_q, ifAdel_d;
  logic        pendV_q, pendV_d;
  logic [31:0] pendPc_q, pendPc_d;

  logic        mis;
  logic        rdy;
  logic        adv;

  // A misaligned fetch never touches imem, so it counts as an immediate
  // completion that produces an address-error entry instead of a word.
  assign mis = (pcF_q[1:0] != 2'b00);
  assign rdy = imem_ready | mis;
  assign adv = rdy & ~stall_d;

  assign imem_addr = pcF_q;
  assign instr_d   = ifInstr_q;
  assign pc_d      = ifPc_q;
  assign valid_d   = ifValid_q;
  assign bd_d      = ifBd_q;
  assign adel_d    = ifAdel_q;

  // Next-state selection: flushes beat stalls, stalls beat wait states, and a
  // branch seen during a wait state is parked until the delay slot arrives.
  always_comb begin
    pcF_d     = pcF_q;
    ifInstr_d = ifInstr_q;
    ifPc_d    = ifPc_q;
    ifValid_d = ifValid_q;
    ifBd_d    = ifBd_q;
    ifAdel_d  = ifAdel_q;
    pendV_d   = pendV_q;
    pendPc_d  = pendPc_q;

    if (exc_redirect || eret_redirect) begin
      pcF_d     = exc_redirect ? EXC_VECTOR : epc;
      ifInstr_d = 32'h0;
      ifPc_d    = 32'h0;
      ifValid_d = 1'b0;
      ifBd_d    = 1'b0;
      ifAdel_d  = 1'b0;
      pendV_d   = 1'b0;
    end else if (stall_d) begin
      pcF_d = pcF_q;
    end else if (!rdy) begin
      ifInstr_d = 32'h0;
      ifValid_d = 1'b0;
      ifBd_d    = 1'b0;
      ifAdel_d  = 1'b0;
      if (br_redirect) begin
        pendV_d  = 1'b1;
        pendPc_d = br_target;
      end
    end else if (adv) begin
      ifInstr_d = mis ? 32'h0 : imem_rdata;
      ifPc_d    = pcF_q;
      ifValid_d = 1'b1;
      ifAdel_d  = mis;
      ifBd_d    = br_redirect | pendV_q;
      if (br_redirect) begin
        pcF_d = br_target;
      end else if (pendV_q) begin
        pcF_d = pendPc_q;
      end else begin
        pcF_d = pcF_q + 32'd4;
      end
      pendV_d = 1'b0;
    end
  end

  // State registers; reset discards any in-flight fetch or parked redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcF_q     <= RESET_PC;
      ifInstr_q <= 32'h0;
      ifPc_q    <= 32'h0;
      ifValid_q <= 1'b0;
      ifBd_q    <= 1'b0;
      ifAdel_q  <= 1'b0;
      pendV_q   <= 1'b0;
      pendPc_q  <= 32'h0;
    end else begin
      pcF_q     <= pcF_d;
      ifInstr_q <= ifInstr_d;
      ifPc_q    <= ifPc_d;
      ifValid_q <= ifValid_d;
      ifBd_q    <= ifBd_d;
      ifAdel_q  <= ifAdel_d;
      pendV_q   <= pendV_d;
      pendPc_q  <= pendPc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a transaction-level model of the fetch
// stream feeds a scoreboard queue that a negedge monitor drains.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC   = 32'h0000_3000;
  localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;

  typedef enum {K_HOLD, K_BUBBLE, K_FLUSH, K_NEW} edgeKind_e;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        bd;
    logic        adel;
  } entry_t;

  logic        clk;
  logic        resetN;
  logic        stall;
  logic        br;
  logic [31:0] brTarget;
  logic        eret;
  logic [31:0] epc;
  logic        exc;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        imemReady;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        validD;
  logic        bdD;
  logic        adelD;

  int tests;
  int errors;

  entry_t      expQ[$];
  logic [31:0] mPend[$];
  logic [31:0] mPc;
  edgeKind_e   kind;
  bit          checkEn;
  entry_t      shown;
  logic        shownValid;
  bit          pcKnown;

  fetch_stage #(
    .RESET_PC  (RESET_PC),
    .EXC_VECTOR(EXC_VECTOR)
  ) dut (
    .clk          (clk),
    .reset        (resetN),
    .stall_d      (stall),
    .br_redirect  (br),
    .br_target    (brTarget),
    .eret_redirect(eret),
    .epc          (epc),
    .exc_redirect (exc),
    .imem_addr    (imemAddr),
    .imem_rdata   (imemRdata),
    .imem_ready   (imemReady),
    .instr_d      (instrD),
    .pc_d         (pcD),
    .valid_d      (validD),
    .bd_d         (bdD),
    .adel_d       (adelD)
  );

  // Instruction memory contents: a fixed, address-dependent, nonzero pattern.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ a[15:0] ^ 16'h5A5A};
  endfunction

  assign imemRdata = memWord(imemAddr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour of one clock edge, expressed in terms of whole fetch
  // transactions: a fetch either completes and delivers an entry, or waits.
  task automatic modelEdge();
    entry_t      e;
    logic [31:0] nxt;
    if (exc || eret) begin
      mPc = exc ? EXC_VECTOR : epc;
      mPend.delete();
      kind = K_FLUSH;
    end else if (stall) begin
      kind = K_HOLD;
    end else if (imemReady || (mPc % 4 != 0)) begin
      e.pc    = mPc;
      e.adel  = (mPc % 4 != 0);
      e.instr = e.adel ? 32'h0 : memWord(mPc);
      e.bd    = br || (mPend.size() != 0);
      if (br)                    nxt = brTarget;
      else if (mPend.size() != 0) nxt = mPend[0];
      else                        nxt = mPc + 32'd4;
      mPend.delete();
      expQ.push_back(e);
      mPc  = nxt;
      kind = K_NEW;
    end else begin
      if (br) begin
        mPend.delete();
        mPend.push_back(brTarget);
      end
      kind = K_BUBBLE;
    end
  endtask

  task automatic applyStimulus(input logic s, input logic b, input logic [31:0] t,
                               input logic er, input logic [31:0] ep,
                               input logic ex, input logic rd);
    stall     = s;
    br        = b;
    brTarget  = t;
    eret      = er;
    epc       = ep;
    exc       = ex;
    imemReady = rd;
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic doReset();
    checkEn = 0;
    resetN  = 1'b0;
    stall = 0; br = 0; brTarget = 0; eret = 0; epc = 0; exc = 0; imemReady = 1;
    mPc = RESET_PC;
    mPend.delete();
    expQ.delete();
    shown      = '{pc: 32'h0, instr: 32'h0, bd: 1'b0, adel: 1'b0};
    shownValid = 1'b0;
    pcKnown    = 1;
    kind       = K_HOLD;
    repeat (2) @(negedge clk);
    checkOutput("rst_imem_addr", imemAddr, RESET_PC);
    checkOutput("rst_instr_d", instrD, 32'h0);
    checkOutput("rst_pc_d", pcD, 32'h0);
    checkOutput("rst_valid_d", {31'h0, validD}, 32'h0);
    checkOutput("rst_bd_d", {31'h0, bdD}, 32'h0);
    checkOutput("rst_adel_d", {31'h0, adelD}, 32'h0);
    @(posedge clk);
    #1;
    resetN  = 1'b1;
    checkEn = 1;
  endtask

  // Monitor: after each edge, pop a new entry when one was delivered and
  // compare the visible IF/ID contents and the fetch address.
  always @(negedge clk) begin
    if (checkEn) begin
      case (kind)
        K_NEW: begin
          if (expQ.size() == 0) begin
            tests++;
            errors++;
            $display("[TB] FAIL scoreboard_empty: got a delivery, expected none at %0t", $time);
          end else begin
            shown      = expQ.pop_front();
            shownValid = 1'b1;
            pcKnown    = 1;
          end
        end
        K_BUBBLE: begin
          shown.instr = 32'h0;
          shown.bd    = 1'b0;
          shown.adel  = 1'b0;
          shownValid  = 1'b0;
          pcKnown     = 0;
        end
        K_FLUSH: begin
          shown      = '{pc: 32'h0, instr: 32'h0, bd: 1'b0, adel: 1'b0};
          shownValid = 1'b0;
          pcKnown    = 1;
        end
        default: begin
        end
      endcase
      kind = K_HOLD;
      checkOutput("imem_addr", imemAddr, mPc);
      checkOutput("valid_d", {31'h0, validD}, {31'h0, shownValid});
      checkOutput("instr_d", instrD, shown.instr);
      checkOutput("bd_d", {31'h0, bdD}, {31'h0, shown.bd});
      checkOutput("adel_d", {31'h0, adelD}, {31'h0, shown.adel});
      if (pcKnown) checkOutput("pc_d", pcD, shown.pc);
    end
  end

  task automatic randomCycles(input int n);
    logic [31:0] t;
    logic [31:0] ep;
    int          r;
    for (int i = 0; i < n; i++) begin
      t = 32'h3000 + ($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 9) == 0) t = t + $urandom_range(1, 3);
      ep = 32'h3000 + ($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 4) == 0) ep = ep + $urandom_range(1, 3);
      r = $urandom_range(0, 99);
      applyStimulus($urandom_range(0, 99) < 20,
                    $urandom_range(0, 99) < 15,
                    t,
                    (r >= 3) && (r < 6),
                    ep,
                    r < 3,
                    $urandom_range(0, 99) < 70);
    end
  endtask

  initial begin
    tests  = 0;
    errors = 0;
    doReset();

    // Sequential fetch with zero-wait memory.
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 1);
    // Decode stall freezes IF/ID and the fetch address.
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    // Taken branch while F holds 0x3010: delay slot then target.
    applyStimulus(0, 1, 32'h3100, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    // Branch during imem wait states is parked until the delay slot lands.
    applyStimulus(0, 0, 0, 1, 32'h3010, 0, 1);
    applyStimulus(0, 1, 32'h3100, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h3100, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    // Exception beats a branch and a stall in the same cycle.
    applyStimulus(1, 1, 32'h3100, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    // Misaligned eret target delivers an address-error entry without imem.
    applyStimulus(0, 0, 0, 1, 32'h3002, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);

    randomCycles(3000);
    doReset();
    randomCycles(1500);

    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    checkOutput("queue_drained", expQ.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined MIPS core, directly upstream of decode.
- Owns the PC register and the IF/ID pipeline register, and drives the instruction-memory address.
- Accepts redirects for exception entry, eret and branch/jump, with one architectural delay slot.
- Handles imem wait states, decode stalls and misaligned-fetch detection.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset
EXC_VECTOR, 32'h0000_4180, exception entry address

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-low reset
stall_d  input  1  decode stall; IF/ID and PC hold
br_redirect  input  1  branch/jump in D resolved taken (pulse per resolution)
br_target  input  32  branch/jump target
eret_redirect  input  1  eret committed; fetch from epc
epc  input  32  return address for eret
exc_redirect  input  1  exception taken; flush and vector
imem_addr  output  32  fetch address (= pc_f, combinational)
imem_rdata  input  32  instruction word, valid when imem_ready=1
imem_ready  input  1  imem returns data this cycle
instr_d  output  32  IF/ID instruction
pc_d  output  32  IF/ID PC
valid_d  output  1  IF/ID holds a real instruction
bd_d  output  1  IF/ID instruction is a branch delay slot
adel_d  output  1  IF/ID fetch address misaligned

Behaviour:
- Reset (reset=0, async):
  - pc_f=RESET_PC.
  - instr_d=0, pc_d=0, valid_d=0, bd_d=0, adel_d=0.
  - pend_v=0, pend_pc=0.
  - Release takes effect on the next rising edge.
- Misalignment:
  - mis = (pc_f[1:0]!=0).
  - When mis=1, the stage treats fetch as ready and ignores imem_rdata/imem_ready.
  - rdy = imem_ready | mis.
- adv = rdy & ~stall_d.
- Priority each edge (highest first):
  1. exc_redirect:
     - pc_f<=EXC_VECTOR.
     - IF/ID cleared to bubble: instr 0, valid 0, bd 0, adel 0, pc_d 0.
     - pend_v<=0.
     - Ignores stall_d and rdy.
  2. eret_redirect: identical to exc_redirect, but pc_f<=epc.
  3. stall_d=1:
     - pc_f, IF/ID and pend hold.
     - br_redirect is ignored; decode re-asserts it while stalled.
  4. rdy=0 (no stall):
     - pc_f holds.
     - IF/ID loads a bubble (valid 0, instr 0, bd 0, adel 0).
     - If br_redirect=1, then pend_v<=1 and pend_pc<=br_target, because the delay slot is still in flight.
  5. adv=1:
     - IF/ID loads instr_d<=(mis?0:imem_rdata), pc_d<=pc_f, valid_d<=1, adel_d<=mis, bd_d<=br_redirect|pend_v.
     - Next PC is br_target if br_redirect, else pend_pc if pend_v, else pc_f+4 (mod 2^32).
     - pend_v<=0.
- Delay slot:
  - The instruction in F when br_redirect is accepted is always delivered to D with bd_d=1 and is never squashed by a branch.
  - The target is fetched in the following fetch.
  - br_redirect and pend_v together (illegal: branch in delay slot) selects br_target.
- Latency:
  - Zero-wait imem gives one instruction per cycle.
  - Redirect to first target fetch is 1 cycle for exc/eret and 2 cycles for a branch (delay slot in between).
- Misaligned epc or br_target produces an adel_d=1 entry one fetch later; no imem wait occurs for it.
- Reset asserted mid-wait or with pending redirect discards all state.

Test Plan:
1. Reset, imem_ready=1 constant, sequential words -> pc_d sequence 0x3000, 0x3004, 0x3008 on consecutive cycles; valid_d=1 from the first edge after release.
2. stall_d=1 for 3 cycles while instr_d=word@0x3008 -> instr_d, pc_d and imem_addr=0x300C all frozen; the fetch resumes with 0x300C, no duplicates or drops.
3. br_redirect=1, br_target=0x3100 while F holds 0x3010 -> D receives 0x3010 with bd_d=1, then 0x3100 with bd_d=0.
4. br_redirect with imem_ready=0 for 2 cycles -> two bubbles (valid_d=0), pend_v set; then 0x3010 with bd_d=1, then 0x3100.
5. exc_redirect and br_redirect in the same cycle with stall_d=1 -> IF/ID bubble, pend_v=0, next fetch address 0x4180.
6. eret_redirect with epc=0x3002 -> bubble, then pc_d=0x3002, adel_d=1, instr_d=0, valid_d=1 with imem_ready held 0; the next fetch address is 0x3006.
